packet_retry_ctrl: RTL

//  Read-side sequencer for packet_fifo: gates the FIFO output onto the link one packet at a time,

---
 rtl/packet_retry_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/packet_retry_ctrl.sv
// Read-side retry sequencer for packet_fifo: one packet at a time onto the link, then ACK/NAK/timeout handling.
// Optional statistics counters are enabled by defining PACKET_RETRY_STATS_EN.
module packet_retry_ctrl #(
   parameter  int WIDTH     = 8,
   parameter  int TIMEOUT   = 1024,
   parameter  int MAX_RETRY = 3,
   localparam int TBITS     = $clog2(TIMEOUT),
   localparam int RBITS     = $clog2(MAX_RETRY + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             enable_i,
   input  logic             ack_i,
   input  logic             nak_i,
   input  logic             s_tvalid,
   output logic             s_tready,
   input  logic             s_tlast,
   input  logic [WIDTH-1:0] s_tdata,
   output logic             m_tvalid,
   input  logic             m_tready,
   output logic             m_tlast,
   output logic [WIDTH-1:0] m_tdata,
   output logic             redo_o,
   output logic             next_o,
   output logic             busy_o,
   output logic             fail_o,
   output logic [RBITS-1:0] tries_o
`ifdef PACKET_RETRY_STATS_EN
  ,output logic [15:0]      sent_cnt_o,
   output logic [15:0]      retry_cnt_o,
   output logic [15:0]      fail_cnt_o
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SEND,
      S_WAIT,
      S_REPLAY,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [TBITS-1:0]   timer_q, timer_d;
   logic [RBITS-1:0]   tries_q, tries_d;
   logic               rphase_q, rphase_d;
   logic               redo_q, redo_d;
   logic               next_q, next_d;
   logic               fail_q, fail_d;
   logic               failure;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         timer_q  <= '0;
         tries_q  <= '0;
         rphase_q <= 1'b0;
         redo_q   <= 1'b0;
         next_q   <= 1'b0;
         fail_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         tries_q  <= tries_d;
         rphase_q <= rphase_d;
         redo_q   <= redo_d;
         next_q   <= next_d;
         fail_q   <= fail_d;
      end
   end

   // A timeout only counts as failure when no ack arrives in the same cycle
   assign failure = !ack_i && (nak_i || (timer_q == '0));

   always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      tries_d  = tries_q;
      rphase_d = 1'b0;
      redo_d   = 1'b0;
      next_d   = 1'b0;
      fail_d   = 1'b0;
      m_tvalid = 1'b0;
      s_tready = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (enable_i && s_tvalid) begin
               state_d = S_SEND;
               tries_d = '0;
            end
         end
         S_SEND: begin
            m_tvalid = s_tvalid;
            s_tready = m_tready;
            if (s_tvalid && m_tready && s_tlast) begin
               state_d = S_WAIT;
               timer_d = TBITS'(TIMEOUT - 1);
            end
         end
         S_WAIT: begin
            if (timer_q != '0)
               timer_d = timer_q - 1'b1;
            if (ack_i) begin
               next_d  = 1'b1;
               state_d = S_DONE;
            end else if (failure) begin
               if (tries_q < RBITS'(MAX_RETRY)) begin
                  redo_d  = 1'b1;
                  tries_d = tries_q + 1'b1;
                  state_d = S_REPLAY;
               end else begin
                  next_d  = 1'b1;
                  fail_d  = 1'b1;
                  state_d = S_DONE;
               end
            end
         end
         S_REPLAY: begin
            // Two cycles: FIFO read address reload, then its read-valid refresh
            if (rphase_q)
               state_d = S_SEND;
            else
               rphase_d = 1'b1;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign m_tdata = s_tdata;
   assign m_tlast = s_tlast;
   assign redo_o  = redo_q;
   assign next_o  = next_q;
   assign fail_o  = fail_q;
   assign busy_o  = (state_q != S_IDLE);
   assign tries_o = tries_q;

`ifdef PACKET_RETRY_STATS_EN
   logic [15:0] sent_q, retry_q, failc_q;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sent_q  <= '0;
         retry_q <= '0;
         failc_q <= '0;
      end else begin
         if (next_q && !fail_q && (sent_q != '1))
            sent_q <= sent_q + 1'b1;
         if (redo_q && (retry_q != '1))
            retry_q <= retry_q + 1'b1;
         if (fail_q && (failc_q != '1))
            failc_q <= failc_q + 1'b1;
      end
   end

   assign sent_cnt_o  = sent_q;
   assign retry_cnt_o = retry_q;
   assign fail_cnt_o  = failc_q;
`endif

endmodule
